// File: rtl/mmult_result_printer.sv
// mmult_result_printer: captures an NxN unsigned result matrix and streams it as right-justified decimal ASCII.
// Define MMULT_PRINT_HEADER_EN to prefix the dump with "C=\r\n".
module mmult_result_printer #(
    parameter int N       = 3,
    parameter int ENTRY_W = 18,
    parameter int DIGITS  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [0:N*N*ENTRY_W-1]     C_mat,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       done
);
    localparam int TOT = N * N * ENTRY_W;
    localparam int BW  = 4 * DIGITS;
    localparam int IW  = $clog2(N * N);
    localparam int CW  = N > 1 ? $clog2(N) : 1;
    localparam int SW  = $clog2(ENTRY_W);
    localparam int PW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(N - 1);
    localparam logic [SW-1:0] LAST_BIT = SW'(ENTRY_W - 1);
    localparam logic [PW-1:0] LAST_POS = PW'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef MMULT_PRINT_HEADER_EN
        HEADER,
`endif
        CONV,
        EMIT,
        SEP,
        FIN
    } state_t;

    state_t              state_q;
    logic [TOT-1:0]      cap_q;
    logic [IW-1:0]       idx_q;
    logic [CW-1:0]       col_q;
    logic [ENTRY_W-1:0]  bin_q;
    logic [BW-1:0]       bcd_q, bcd_adj, bcd_d;
    logic [SW-1:0]       cnt_q;
    logic [PW-1:0]       pos_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q, busy_q, done_q;
    logic                xfer;
`ifdef MMULT_PRINT_HEADER_EN
    logic [1:0]          hdr_q;

    function automatic logic [7:0] hdr_byte(input logic [1:0] h);
        return h == 2'd0 ? 8'h43 : h == 2'd1 ? 8'h3D : h == 2'd2 ? 8'h0D : 8'h0A;
    endfunction
`endif

    // Leading zeros blank to space, but the units digit always prints.
    function automatic logic [7:0] digit_char(input logic [BW-1:0] b, input logic [PW-1:0] p);
        logic [BW-1:0] s;
        s = b >> (4 * (DIGITS - 1 - int'(p)));
        return (int'(p) != DIGITS - 1 && s == '0) ? 8'h20 : {4'h3, s[3:0]};
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++)
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
        bcd_d = {bcd_adj[BW-2:0], bin_q[ENTRY_W-1]};
    end

    assign xfer     = tx_valid_q && tx_ready;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // The current entry always sits in the top ENTRY_W bits of cap_q; advancing shifts it out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            idx_q      <= '0;
            col_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pos_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MMULT_PRINT_HEADER_EN
            hdr_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (valid) begin
                    cap_q  <= C_mat;
                    idx_q  <= '0;
                    col_q  <= '0;
                    busy_q <= 1'b1;
`ifdef MMULT_PRINT_HEADER_EN
                    hdr_q   <= '0;
                    state_q <= HEADER;
`else
                    bin_q   <= C_mat[0 +: ENTRY_W];
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= CONV;
`endif
                end
`ifdef MMULT_PRINT_HEADER_EN
                HEADER: if (!tx_valid_q) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= hdr_byte(hdr_q);
                end else if (tx_ready) begin
                    if (hdr_q == 2'd3) begin
                        tx_valid_q <= 1'b0;
                        bin_q      <= cap_q[TOT-1 -: ENTRY_W];
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= CONV;
                    end else begin
                        hdr_q     <= hdr_q + 2'd1;
                        tx_data_q <= hdr_byte(hdr_q + 2'd1);
                    end
                end
`endif
                CONV: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q    <= EMIT;
                        pos_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= digit_char(bcd_d, '0);
                    end
                end
                EMIT: if (xfer) begin
                    if (pos_q == LAST_POS) begin
                        state_q   <= SEP;
                        pos_q     <= '0;
                        tx_data_q <= col_q == LAST_COL ? 8'h0D : 8'h20;
                    end else begin
                        pos_q     <= pos_q + 1'b1;
                        tx_data_q <= digit_char(bcd_q, pos_q + 1'b1);
                    end
                end
                SEP: if (xfer) begin
                    if (col_q == LAST_COL && pos_q == '0) begin
                        pos_q     <= PW'(1);
                        tx_data_q <= 8'h0A;
                    end else begin
                        tx_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            col_q   <= col_q == LAST_COL ? '0 : col_q + 1'b1;
                            cap_q   <= cap_q << ENTRY_W;
                            bin_q   <= cap_q[TOT-1-ENTRY_W -: ENTRY_W];
                            bcd_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= CONV;
                        end
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmult_result_printer.sv
// tb_mmult_result_printer: directed checks of the matrix text dump, handshake, reset abort and re-trigger rules.
module tb_mmult_result_printer;
    localparam int N = 3, W = 18, TOT = N * N * W;
`ifdef MMULT_PRINT_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NBYTES   = 66 + 4 * HDR;
    localparam int FIRST_V  = HDR ? 1 : 18;
    localparam int DONE_CYC = 228 + 5 * HDR;
    localparam logic [7:0] BP_BYTE = HDR ? 8'h0D : 8'h35;

    logic clk = 1'b0, reset = 1'b1, valid = 1'b0, tx_ready = 1'b1;
    logic [0:TOT-1] C_mat = '0;
    logic [7:0] tx_data;
    logic tx_valid, busy, done;

    int n_checks = 0, n_fail = 0, done_cnt = 0;
    byte unsigned got_q[$], exp_q[$];
    int mat_a[9] = '{195075, 7, 100000, 262143, 10, 0, 1, 99999, 123456};
    int mat_b[9] = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
    string zero_txt = {"     0      0      0\r\n", "     0      0      0\r\n", "     0      0      0\r\n"};
    string a_txt    = {"195075      7 100000\r\n", "262143     10      0\r\n", "     1  99999 123456\r\n"};

    mmult_result_printer dut (
        .clk(clk), .reset(reset), .valid(valid), .C_mat(C_mat),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && tx_valid === 1'b1 && tx_ready) got_q.push_back(tx_data);
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [0:TOT-1] pack(input int v[9]);
        logic [0:TOT-1] m;
        for (int i = 0; i < 9; i++) m[i*W +: W] = W'(v[i]);
        return m;
    endfunction

    task automatic set_exp(input string s);
        exp_q.delete();
        if (HDR != 0) begin
            exp_q.push_back(8'h43); exp_q.push_back(8'h3D); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        end
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    function automatic int first_diff();
        int n;
        n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) return i;
        return got_q.size() == exp_q.size() ? -1 : n;
    endfunction

    task automatic start_dump(input logic [0:TOT-1] m);
        @(posedge clk); #1;
        C_mat = m;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output int cyc, output int first_v);
        cyc = 0;
        first_v = -1;
        while (cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (first_v < 0 && tx_valid) first_v = cyc;
            if (done) break;
        end
    endtask

    task automatic wait_bytes(input int n);
        for (int c = 0; c < 400 && got_q.size() < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
    endtask

    task automatic test_zero();
        int cyc, fv, d0, df;
        got_q.delete();
        set_exp(zero_txt);
        d0 = done_cnt;
        start_dump('0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_start: got %b want 1", busy); end
        run_until_done(600, cyc, fv);
        n_checks++; if (fv != FIRST_V) begin n_fail++; $display("FAIL zero_first_valid: got cycle %0d want %0d", fv, FIRST_V); end
        n_checks++; if (done !== 1'b1 || cyc != DONE_CYC) begin n_fail++; $display("FAIL zero_done_cycle: got %0d (done=%b) want %0d", cyc, done, DONE_CYC); end
        repeat (3) @(posedge clk);
        #1;
        df = first_diff();
        n_checks++; if (got_q.size() != NBYTES) begin n_fail++; $display("FAIL zero_count: got %0d bytes want %0d", got_q.size(), NBYTES); end
        n_checks++; if (df != -1) begin n_fail++; $display("FAIL zero_stream: first difference at byte %0d (got %0d bytes, want %0d)", df, got_q.size(), exp_q.size()); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt - d0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_matrix();
        int cyc, fv, df;
        got_q.delete();
        set_exp(a_txt);
        start_dump(pack(mat_a));
        run_until_done(600, cyc, fv);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL matrix_done: got %b want 1 within 600 cycles", done); end
        df = first_diff();
        n_checks++; if (df != -1) begin n_fail++; $display("FAIL matrix_stream: first difference at byte %0d (got %0d bytes, want %0d)", df, got_q.size(), exp_q.size()); end
        n_checks++; if (got_q.size() > 4*HDR && got_q[4*HDR] !== 8'h31) begin n_fail++; $display("FAIL matrix_byte0: got %h want 31", got_q[4*HDR]); end
        n_checks++; if (got_q.size() > 4*HDR + 22 && (got_q[4*HDR+21] !== 8'h0A || got_q[4*HDR+22] !== 8'h32)) begin
            n_fail++; $display("FAIL matrix_row_break: got %h %h want 0a 32", got_q[4*HDR+21], got_q[4*HDR+22]);
        end
    endtask

    task automatic test_backpressure();
        int cyc, fv, df;
        bit ok_v, ok_d;
        got_q.delete();
        set_exp(a_txt);
        start_dump(pack(mat_a));
        wait_bytes(2);
        tx_ready = 1'b0;
        ok_v = 1'b1;
        ok_d = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (tx_valid !== 1'b1) ok_v = 1'b0;
            if (tx_data !== BP_BYTE) ok_d = 1'b0;
        end
        n_checks++; if (!ok_v) begin n_fail++; $display("FAIL bp_valid_held: tx_valid=%b want 1 throughout stall", tx_valid); end
        n_checks++; if (!ok_d) begin n_fail++; $display("FAIL bp_data_held: tx_data=%h want %h throughout stall", tx_data, BP_BYTE); end
        n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL bp_no_transfer: got %0d bytes during stall want 2", got_q.size()); end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        run_until_done(600, cyc, fv);
        df = first_diff();
        n_checks++; if (got_q.size() != NBYTES) begin n_fail++; $display("FAIL bp_count: got %0d bytes want %0d", got_q.size(), NBYTES); end
        n_checks++; if (df != -1) begin n_fail++; $display("FAIL bp_stream: first difference at byte %0d", df); end
    endtask

    task automatic test_ignore_valid();
        int cyc, fv, df;
        got_q.delete();
        set_exp(a_txt);
        start_dump(pack(mat_a));
        wait_bytes(10);
        C_mat = pack(mat_b);
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        run_until_done(600, cyc, fv);
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_fin_valid: busy=%b want 0", busy); end
        repeat (5) @(posedge clk);
        #1;
        df = first_diff();
        n_checks++; if (df != -1) begin n_fail++; $display("FAIL ignore_stream: first difference at byte %0d (got %0d bytes, want %0d)", df, got_q.size(), exp_q.size()); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: tx_valid=%b want 0", tx_valid); end
    endtask

    task automatic test_reset_midstream();
        int cyc, fv, d0, df;
        got_q.delete();
        set_exp(zero_txt);
        start_dump(pack(mat_a));
        wait_bytes(30);
        reset = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL abort_tx: valid=%b data=%h want 0 00", tx_valid, tx_data); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_status: busy=%b done=%b want 0 0", busy, done); end
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (done_cnt != d0 || got_q.size() != 30) begin n_fail++; $display("FAIL abort_quiet: done pulses %0d bytes %0d want 0 and 30", done_cnt - d0, got_q.size()); end
        got_q.delete();
        start_dump('0);
        run_until_done(600, cyc, fv);
        repeat (2) @(posedge clk);
        #1;
        df = first_diff();
        n_checks++; if (df != -1) begin n_fail++; $display("FAIL abort_fresh_stream: first difference at byte %0d (got %0d bytes)", df, got_q.size()); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL abort_fresh_done: got %0d pulses want 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int cyc, fv, d0, n;
        got_q.delete();
        set_exp(zero_txt);
        n = exp_q.size();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_q[i]);
        d0 = done_cnt;
        @(posedge clk); #1;
        C_mat = '0;
        valid = 1'b1;
        run_until_done(600, cyc, fv);
        run_until_done(600, cyc, fv);
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done: got %0d pulses want 2", done_cnt - d0); end
        n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL b2b_stream: got %0d bytes want %0d", got_q.size(), 2 * NBYTES); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_matrix();
        test_backpressure();
        test_ignore_valid();
        test_reset_midstream();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
